// File: rtl/lru_tag_alloc.sv
// lru_tag_alloc
// Fully-associative tag store with allocate-on-miss. Each request is
// accepted in IDLE and compared against every valid entry in LOOKUP. A hit
// returns the matching entry. A miss writes the tag into a victim entry and
// returns that entry. The victim is the lowest-indexed invalid entry if one
// exists, otherwise the entry named by the external LRU on lru_idx. The
// result is then held in RESP until it is consumed.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   req_valid/req_ready   request handshake, req_tag = tag to look up
//   rsp_valid/rsp_ready   response handshake
//   rsp_hit, rsp_idx      lookup result (hit entry or allocated victim)
//   flush                 level; clears all valid bits while IDLE
//   acc_en, acc_idx       one-cycle touch pulse to the matrix LRU
//   lru_idx               least-recently-used entry from the matrix LRU
//   hit_cnt, miss_cnt     16-bit saturating counters (only when
//                         LRU_TAG_ALLOC_STATS_EN is defined)
//
// Optional feature macro: LRU_TAG_ALLOC_STATS_EN

module lru_tag_alloc #(
  parameter int NO_ENTRY  = 8,
  parameter int IDX_WIDTH = $clog2(NO_ENTRY),
  parameter int TAG_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_hit,
  output logic [IDX_WIDTH-1:0] rsp_idx,
  input  logic                 flush,
  output logic                 acc_en,
  output logic [IDX_WIDTH-1:0] acc_idx,
`ifdef LRU_TAG_ALLOC_STATS_EN
  output logic [15:0]          hit_cnt,
  output logic [15:0]          miss_cnt,
`endif
  input  logic [IDX_WIDTH-1:0] lru_idx
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                 state;
  logic [TAG_WIDTH-1:0]   tags [NO_ENTRY];
  logic [NO_ENTRY-1:0]    valid;
  logic [TAG_WIDTH-1:0]   tag_q;

  logic                   hit;
  logic [IDX_WIDTH-1:0]   hit_idx;
  logic                   free_any;
  logic [IDX_WIDTH-1:0]   free_idx;
  logic [IDX_WIDTH-1:0]   victim;
  logic [IDX_WIDTH-1:0]   sel_idx;

  // Descending scan so the lowest-indexed match/free entry is the one kept.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NO_ENTRY - 1; i >= 0; i--) begin
      if (valid[i] && (tags[i] == tag_q)) begin
        hit     = 1'b1;
        hit_idx = IDX_WIDTH'(i);
      end
      if (!valid[i]) begin
        free_any = 1'b1;
        free_idx = IDX_WIDTH'(i);
      end
    end
  end

  assign victim  = free_any ? free_idx : lru_idx;
  assign sel_idx = hit ? hit_idx : victim;

  assign req_ready = (state == IDLE) && !flush;
  assign rsp_valid = (state == RESP) && !rst;
  // The touch pulse must carry the index resolved this cycle (it depends on
  // lru_idx as seen in LOOKUP), so it is decoded from state, not registered.
  // Gating with rst keeps a reset during LOOKUP from touching the LRU.
  assign acc_en    = (state == LOOKUP) && !rst;
  assign acc_idx   = acc_en ? sel_idx : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      valid    <= '0;
      tag_q    <= '0;
      rsp_hit  <= 1'b0;
      rsp_idx  <= '0;
`ifdef LRU_TAG_ALLOC_STATS_EN
      hit_cnt  <= '0;
      miss_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Flush has priority over a simultaneous request.
          if (flush) begin
            valid <= '0;
          end else if (req_valid) begin
            tag_q <= req_tag;
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          rsp_hit <= hit;
          rsp_idx <= sel_idx;
          if (!hit) begin
            tags[victim]  <= tag_q;
            valid[victim] <= 1'b1;
          end
`ifdef LRU_TAG_ALLOC_STATS_EN
          if (hit && (hit_cnt != 16'hFFFF))
            hit_cnt <= hit_cnt + 16'd1;
          if (!hit && (miss_cnt != 16'hFFFF))
            miss_cnt <= miss_cnt + 16'd1;
`endif
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lru_tag_alloc.sv
// tb_lru_tag_alloc
// Self-checking bench for lru_tag_alloc: a directed vector table, directed
// sequences for stall / flush / reset corner cases, and a randomized phase
// checked against a behavioural tag-store model.
// Define LRU_TAG_ALLOC_STATS_EN to also exercise the statistics counters.

module tb_lru_tag_alloc;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [TW-1:0] req_tag;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_hit;
  logic [IW-1:0] rsp_idx;
  logic          flush;
  logic          acc_en;
  logic [IW-1:0] acc_idx;
  logic [IW-1:0] lru_idx;
`ifdef LRU_TAG_ALLOC_STATS_EN
  logic [15:0]   hit_cnt;
  logic [15:0]   miss_cnt;
`endif

  always #5 clk = ~clk;

  lru_tag_alloc #(.NO_ENTRY(N), .IDX_WIDTH(IW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hit(rsp_hit), .rsp_idx(rsp_idx),
    .flush(flush), .acc_en(acc_en), .acc_idx(acc_idx),
`ifdef LRU_TAG_ALLOC_STATS_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .lru_idx(lru_idx)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: an array of tags with presence flags.
  logic [TW-1:0] m_tag   [N];
  bit            m_valid [N];

  typedef struct {
    logic [TW-1:0] tag;
    logic [IW-1:0] lru;
    logic          exp_hit;
    logic [IW-1:0] exp_idx;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_valid[i] = 0;
  endtask

  task automatic model_ref(input logic [TW-1:0] tag, input logic [IW-1:0] lru,
                           output logic h, output logic [IW-1:0] idx);
    int free_i;
    h = 1'b0;
    idx = lru;
    free_i = -1;
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_tag[i] == tag) begin h = 1'b1; idx = IW'(i); end
    if (!h) begin
      for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) free_i = i;
      if (free_i >= 0) idx = IW'(free_i);
      m_tag[idx]   = tag;
      m_valid[idx] = 1;
    end
  endtask

  // Called just after a rising edge. Issues one request, optionally raises
  // flush during LOOKUP, stalls the response `stall` cycles, and checks
  // the touch pulse and response against the expected values.
  task automatic do_req(input logic [TW-1:0] tag, input logic [IW-1:0] lru,
                        input logic exp_hit, input logic [IW-1:0] exp_idx,
                        input int stall, input logic flush_mid);
    int w = 0;
    while (!req_ready && w < 20) begin @(posedge clk); #1; w++; end
    check("req_ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    req_tag   = tag;
    lru_idx   = lru;
    rsp_ready = (stall == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    flush     = flush_mid;
    @(negedge clk);
    check("acc_en_lookup", acc_en, 1);
    check("acc_idx_lookup", acc_idx, exp_idx);
    check("rsp_valid_lookup", rsp_valid, 0);
    @(posedge clk); #1;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rsp_hit", rsp_hit, exp_hit);
      check("stall_rsp_idx", rsp_idx, exp_idx);
      check("stall_req_ready", req_ready, 0);
      check("stall_acc_en", acc_en, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_hit", rsp_hit, exp_hit);
    check("rsp_idx", rsp_idx, exp_idx);
    check("acc_en_resp", acc_en, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_valid_after", rsp_valid, 0);
    check("req_ready_after", req_ready, !flush);
  endtask

  task automatic run_model_req(input logic [TW-1:0] tag, input logic [IW-1:0] lru, input int stall);
    logic          h;
    logic [IW-1:0] idx;
    model_ref(tag, lru, h, idx);
    do_req(tag, lru, h, idx, stall, 1'b0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    logic          h;
    logic [IW-1:0] idx;

    for (int i = 0; i < 8; i++) vecs[i] = '{16'h0010 + 16'(i), 3'd0, 1'b0, IW'(i)};
    vecs[8]  = '{16'h0013, 3'd0, 1'b1, 3'd3};
    vecs[9]  = '{16'h00AA, 3'd5, 1'b0, 3'd5};
    vecs[10] = '{16'h00AA, 3'd2, 1'b1, 3'd5};

    rst = 1'b1; req_valid = 1'b0; req_tag = '0; rsp_ready = 1'b0;
    flush = 1'b0; lru_idx = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_hit", rsp_hit, 0);
    check("reset_rsp_idx", rsp_idx, 0);
    check("reset_acc_en", acc_en, 0);
    check("reset_acc_idx", acc_idx, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    check("reset_req_ready", req_ready, 1);

    // Directed table: fill, hit, LRU replacement, re-hit.
    for (int v = 0; v < 11; v++) begin
      model_ref(vecs[v].tag, vecs[v].lru, h, idx);
      do_req(vecs[v].tag, vecs[v].lru, vecs[v].exp_hit, vecs[v].exp_idx, 0, 1'b0);
    end

    // Response held off for 4 cycles.
    model_ref(16'h0013, 3'd0, h, idx);
    do_req(16'h0013, 3'd0, 1'b1, 3'd3, 4, 1'b0);

    // Flush raised during LOOKUP: response unaffected, applied once IDLE.
    model_ref(16'h0011, 3'd0, h, idx);
    do_req(16'h0011, 3'd0, 1'b1, 3'd1, 0, 1'b1);
    @(negedge clk);
    check("flush_idle_acc_en", acc_en, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    model_clear();
    model_ref(16'h0011, 3'd4, h, idx);
    do_req(16'h0011, 3'd4, 1'b0, 3'd0, 0, 1'b0);

    // Flush and request together: flush wins.
    req_valid = 1'b1; req_tag = 16'h0011; flush = 1'b1;
    #1;
    check("conflict_req_ready", req_ready, 0);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("conflict_no_lookup", acc_en, 0);
    @(posedge clk); #1;
    model_clear();
    model_ref(16'h0011, 3'd6, h, idx);
    do_req(16'h0011, 3'd6, 1'b0, 3'd0, 0, 1'b0);

    // Reset during LOOKUP drops the request.
    req_valid = 1'b1; req_tag = 16'h0042; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_lookup_acc_en", acc_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check("rst_mid_req_ready", req_ready, 1);
    @(negedge clk);
    check("rst_mid_acc_en", acc_en, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    model_ref(16'h0011, 3'd7, h, idx);
    do_req(16'h0011, 3'd7, h, idx, 0, 1'b0);

    // Randomized traffic with a small tag pool to get both hits and misses.
    for (int r = 0; r < 80; r++) begin
      if ($urandom_range(0, 9) == 0) begin
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_clear();
      end
      run_model_req(16'h0100 + 16'($urandom_range(0, 11)), IW'($urandom_range(0, N - 1)),
                    int'($urandom_range(0, 2)));
    end

`ifdef LRU_TAG_ALLOC_STATS_EN
    reset_pulse();
    check("stats_reset_hit", hit_cnt, 0);
    check("stats_reset_miss", miss_cnt, 0);
    run_model_req(16'h0200, 3'd0, 0);
    run_model_req(16'h0201, 3'd0, 0);
    run_model_req(16'h0202, 3'd0, 0);
    run_model_req(16'h0200, 3'd0, 0);
    run_model_req(16'h0201, 3'd0, 0);
    check("stats_miss_cnt", miss_cnt, 3);
    check("stats_hit_cnt", hit_cnt, 2);
    req_valid = 1'b1; req_tag = 16'h0203; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    check("stats_rst_rsp_valid", rsp_valid, 0);
    check("stats_rst_hit", hit_cnt, 0);
    check("stats_rst_miss", miss_cnt, 0);
    @(posedge clk); #1;
    check("stats_rst_rsp_valid2", rsp_valid, 0);
    rsp_ready = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lru_tag_alloc.md
LRU_TAG_ALLOC -- requirements
Module: lru_tag_alloc

Interface
REQ-001 SHALL have parameter NO_ENTRY, default 8, number of fully-associative entries (power of two, >=2).
REQ-002 SHALL have parameter IDX_WIDTH, default $clog2(NO_ENTRY), entry index width.
REQ-003 SHALL have parameter TAG_WIDTH, default 16, lookup tag width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  lookup request present.
REQ-007 req_ready  output  1  block accepts request this cycle.
REQ-008 req_tag  input  TAG_WIDTH  tag to look up.
REQ-009 rsp_valid  output  1  lookup result present.
REQ-010 rsp_ready  input  1  downstream consumes result.
REQ-011 rsp_hit  output  1  1 = tag found, 0 = miss, tag allocated.
REQ-012 rsp_idx  output  IDX_WIDTH  entry holding tag (hit entry or allocated victim).
REQ-013 flush  input  1  level; invalidate all entries.
REQ-014 acc_en  output  1  one-cycle pulse: entry touched, to matrix LRU.
REQ-015 acc_idx  output  IDX_WIDTH  touched entry index.
REQ-016 lru_idx  input  IDX_WIDTH  least-recently-used entry from matrix LRU.

Function
REQ-017 SHALL hold per-entry tag register and valid bit; FSM states IDLE, LOOKUP, RESP.
REQ-018 req_ready SHALL equal (state==IDLE) & ~flush; handshake = req_valid & req_ready registers req_tag, IDLE->LOOKUP.
REQ-019 In LOOKUP SHALL compare registered tag against all valid entries in one cycle; at most one match exists.
REQ-020 Hit: rsp_hit=1, rsp_idx=matching index, no tag/valid change.
REQ-021 Miss: victim = lowest-indexed invalid entry if any, else lru_idx sampled in LOOKUP cycle; victim tag written, valid set; rsp_hit=0, rsp_idx=victim.
REQ-022 SHALL pulse acc_en=1 with acc_idx=rsp_idx during the LOOKUP cycle only; acc_en=0 all other cycles.
REQ-023 LOOKUP->RESP unconditionally; rsp_hit/rsp_idx registered at that edge; rsp_valid=1 throughout RESP.
REQ-024 rsp_hit/rsp_idx SHALL stay stable while rsp_valid & ~rsp_ready; RESP->IDLE on rsp_ready.
REQ-025 Latency: accept edge N, rsp_valid high from cycle N+2; minimum 3 cycles per request when rsp_ready held high.
REQ-026 Flush SHALL act only in IDLE: any IDLE cycle with flush=1 clears all valid bits at next edge; tags unaffected; no acc_en.
REQ-027 Flush asserted in LOOKUP/RESP SHALL not disturb the in-flight request; if still high on return to IDLE it is applied then.
REQ-028 req_valid & flush together in IDLE: flush wins, request not accepted.
REQ-029 Same tag requested twice back-to-back: second request SHALL hit the entry allocated by the first.

Reset
REQ-030 rst=1 SHALL force state IDLE, all valid bits 0, rsp_valid=0, rsp_hit=0, rsp_idx=0, acc_en=0, acc_idx=0; tag contents don't-care.
REQ-031 rst mid-transaction SHALL drop the in-flight request without response or acc_en; req_ready=1 on first cycle after rst deasserts (flush=0).

Configuration
REQ-032 Macro LRU_TAG_ALLOC_STATS_EN defined: SHALL add outputs hit_cnt and miss_cnt, 16 bits each, incremented in LOOKUP on hit/miss, saturating at 16'hFFFF, cleared by rst only.
REQ-033 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-034 After reset, tags 0x0010..0x0017 requested in order -> all misses, rsp_idx 0..7, acc_idx 0..7 pulses.
REQ-035 Then tag 0x0013 -> rsp_hit=1, rsp_idx=3, acc_en pulse with acc_idx=3, no tag write.
REQ-036 All 8 valid, LRU model drives lru_idx=5, request tag 0x00AA -> miss, rsp_idx=5, entry 5 tag=0x00AA; re-request 0x00AA -> hit idx 5.
REQ-037 rsp_ready held 0 for 4 cycles in RESP -> rsp_valid, rsp_hit, rsp_idx stable, req_ready=0; release -> IDLE next edge.
REQ-038 flush asserted during LOOKUP of 0x0011 -> response completes normally, valid bits cleared after IDLE return; next 0x0011 -> miss, rsp_idx=0.
REQ-039 With LRU_TAG_ALLOC_STATS_EN: 3 misses + 2 hits -> miss_cnt=3, hit_cnt=2; rst mid-LOOKUP -> no rsp_valid, counters 0.
